// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operation encoding used by the ALU, the arbiter and
// anything that talks to either of them.
//   alu_op_t : ALU_NOP (read accumulator), ALU_ADD (b+a), ALU_SUB (b-a)
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_NOP = 2'd0,
        ALU_ADD = 2'd1,
        ALU_SUB = 2'd2
    } alu_op_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester-side bundle of the ALU arbiter. One slot per
// requester, indexed 0..N_REQ-1.
//   req_valid/req_ready  request handshake
//   req_op/req_a/req_b   operation and 64-bit operands
//   req_lock             keep an exclusive grant after this op
//   rsp_valid/rsp_ready  response handshake (one-deep register per requester)
//   rsp_res/rsp_flags    64-bit result and {zf, cf, of, sf}
//
// Handshake rules: a request transfers in a cycle where req_valid and
// req_ready are both 1; req_ready may depend combinationally on req_valid
// and rsp_ready. A response transfers in a cycle where rsp_valid and
// rsp_ready are both 1; rsp_ready while rsp_valid is 0 has no effect.
// Modports: master = requesting unit, slave = arbiter.
interface alu_arbiter_if #(
    parameter int N_REQ = 2
);

    logic [N_REQ-1:0]  req_valid;
    logic [N_REQ-1:0]  req_ready;
    logic [N_REQ-1:0]  req_lock;
    alu_pkg::alu_op_t  req_op    [N_REQ];
    logic [63:0]       req_a     [N_REQ];
    logic [63:0]       req_b     [N_REQ];
    logic [N_REQ-1:0]  rsp_valid;
    logic [N_REQ-1:0]  rsp_ready;
    logic [63:0]       rsp_res   [N_REQ];
    logic [3:0]        rsp_flags [N_REQ];

    modport master (
        output req_valid, req_op, req_a, req_b, req_lock, rsp_ready,
        input  req_ready, rsp_valid, rsp_res, rsp_flags
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_lock, rsp_ready,
        output req_ready, rsp_valid, rsp_res, rsp_flags
    );

endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 64-bit ALU between N_REQ requesters.
// Round-robin grant in IDLE; a requester issuing with req_lock moves the FSM
// to LOCKED, where only that owner is served until it issues an unlocked op
// or stays idle for LOCK_TIMEOUT consecutive cycles (0 = never time out).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   bus             requester bundle (alu_arbiter_if.slave)
//   alu_op/a/b      operation driven to the ALU (NOP and zero when no grant)
//   alu_res, alu_*f combinational ALU result and flags, captured at the
//                   edge ending the issue cycle
//   lock_owner      owner of the lock, meaningful while locked = 1
//   locked          FSM state (1 = LOCKED)
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    alu_arbiter_if.slave             bus,
    output alu_op_t                  alu_op,
    output logic [63:0]              alu_a,
    output logic [63:0]              alu_b,
    input  logic [63:0]              alu_res,
    input  logic                     alu_zf,
    input  logic                     alu_cf,
    input  logic                     alu_of,
    input  logic                     alu_sf,
    output logic [$clog2(N_REQ)-1:0] lock_owner,
    output logic                     locked
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [CW-1:0]    idle_cnt_q, idle_cnt_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [63:0]      rsp_res_q   [N_REQ];
    logic [63:0]      rsp_res_d   [N_REQ];
    logic [3:0]       rsp_flags_q [N_REQ];
    logic [3:0]       rsp_flags_d [N_REQ];

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] req_ready;
    logic             gnt_valid;
    logic [IW-1:0]    gnt_idx;
    logic             timeout_hit;

    // A requester can be served only if its response slot is free or is
    // being drained in this same cycle.
    assign eligible = bus.req_valid & (~rsp_valid_q | bus.rsp_ready);

    assign timeout_hit = (LOCK_TIMEOUT != 0) &&
                         (idle_cnt_q == CW'(LOCK_TIMEOUT - 1));

    // Grant selection. Walking k from far to near lets the requester closest
    // after rr_ptr overwrite any earlier hit, so it wins.
    always_comb begin
        logic [IW-1:0] cand;
        cand      = '0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (!rst) begin
            if (state_q == ST_LOCKED) begin
                gnt_valid = eligible[owner_q];
                gnt_idx   = owner_q;
            end else begin
                for (int k = N_REQ; k >= 1; k--) begin
                    cand = IW'((int'(rr_ptr_q) + k) % N_REQ);
                    if (eligible[cand]) begin
                        gnt_valid = 1'b1;
                        gnt_idx   = cand;
                    end
                end
            end
        end
    end

    always_comb begin
        alu_op    = ALU_NOP;
        alu_a     = '0;
        alu_b     = '0;
        req_ready = '0;
        if (gnt_valid) begin
            alu_op             = bus.req_op[gnt_idx];
            alu_a              = bus.req_a[gnt_idx];
            alu_b              = bus.req_b[gnt_idx];
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Lock FSM and idle counter.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        idle_cnt_d = idle_cnt_q;
        rr_ptr_d   = gnt_valid ? gnt_idx : rr_ptr_q;
        if (state_q == ST_IDLE) begin
            if (gnt_valid && bus.req_lock[gnt_idx]) begin
                state_d    = ST_LOCKED;
                owner_d    = gnt_idx;
                idle_cnt_d = '0;
            end
        end else begin
            if (gnt_valid) begin
                // An owner grant beats a timeout expiring in the same cycle.
                idle_cnt_d = '0;
                if (!bus.req_lock[gnt_idx]) begin
                    state_d = ST_IDLE;
                end
            end else if (timeout_hit) begin
                state_d    = ST_IDLE;
                idle_cnt_d = '0;
            end else if (LOCK_TIMEOUT != 0) begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
    end

    // Response registers: a fresh capture overrides a drain in the same cycle.
    always_comb begin
        rsp_valid_d = rsp_valid_q & ~bus.rsp_ready;
        rsp_res_d   = rsp_res_q;
        rsp_flags_d = rsp_flags_q;
        if (gnt_valid) begin
            rsp_valid_d[gnt_idx] = 1'b1;
            rsp_res_d[gnt_idx]   = alu_res;
            rsp_flags_d[gnt_idx] = {alu_zf, alu_cf, alu_of, alu_sf};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= IW'(N_REQ - 1);
            owner_q     <= '0;
            idle_cnt_q  <= '0;
            rsp_valid_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                rsp_res_q[i]   <= '0;
                rsp_flags_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            idle_cnt_q  <= idle_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp
        assign bus.rsp_res[gi]   = rsp_res_q[gi];
        assign bus.rsp_flags[gi] = rsp_flags_q[gi];
    end

    assign lock_owner = owner_q;
    assign locked     = (state_q == ST_LOCKED);

endmodule
